// File: rtl/ad9783_spi_cfg_pkg.sv
// Shared definitions for the AD9783 serial-port configuration sequencer.
// Contents: frame layout constants, DAC register addresses, the power-up
// init table, the sequencer and frame-engine state types, and a helper
// that assembles a 16-bit instruction+data frame.
package ad9783_spi_cfg_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned RW_BIT  = 15;   // 1 = read

  localparam logic [4:0] REG_SPI_CTL    = 5'h00;
  localparam logic [4:0] REG_DATA_CTL   = 5'h02;
  localparam logic [4:0] REG_POWER_DN   = 5'h03;
  localparam logic [4:0] REG_SETUP_HOLD = 5'h04;

  typedef enum logic [2:0] {
    ST_RESET_IDLE,
    ST_INIT_LOAD,
    ST_FRAME,
    ST_GAP,
    ST_IDLE
  } cfg_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SHIFT,
    PH_TAIL
  } phy_phase_t;

  // Init table entry {addr[4:0], data[7:0]}; unused slots are 0x00 <= 0x00.
  function automatic logic [12:0] init_entry(input logic [3:0] idx);
    logic [12:0] e;
    case (idx)
      4'd0:    e = {REG_SPI_CTL,    8'h00};
      4'd1:    e = {REG_DATA_CTL,   8'h00};
      4'd2:    e = {REG_POWER_DN,   8'h00};
      4'd3:    e = {REG_SETUP_HOLD, 8'h00};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [FRAME_W-1:0] make_frame(input logic       rd,
                                                    input logic [4:0] addr,
                                                    input logic [7:0] data);
    return {rd, 2'b00, addr, data};
  endfunction

endpackage

// File: rtl/ad9783_spi_phy.sv
// Single 16-bit SPI frame engine for the AD9783 serial port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, frame        load and launch a frame (honoured only when idle)
//   busy                frame or trailing csb-high gap in progress
//   frame_end           strobe in the cycle before csb returns high
//   gap_end             strobe in the last cycle of the csb-high gap
//   rx_data, rx_valid   byte shifted in during a read, 1-cycle valid pulse
//   spi_*               serial port pins (sclk idles low, MSB first)
module ad9783_spi_phy
  import ad9783_spi_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               frame_end,
  output logic               gap_end,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               spi_csb,
  output logic               spi_sclk,
  output logic               spi_sdio,
  input  logic               spi_sdo
);

  localparam int unsigned HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  phy_phase_t         phase, phase_nxt;
  logic [HC_W-1:0]    hcnt;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] tx_sh;
  logic [7:0]         rx_sh;
  logic               is_rd;
  logic               tick;

  // tick marks the last clk of a half-period: SCLK/csb/sdio change on the next edge.
  assign tick      = (phase != PH_IDLE) && (hcnt == HC_W'(CLK_DIV - 1));
  // After falling edge 15 sclk is low with all 16 rising edges counted.
  assign frame_end = (phase == PH_SHIFT) && tick && !spi_sclk && (bit_cnt == 5'd16);
  // Tail counts two half-periods of csb high before the engine frees up.
  assign gap_end   = (phase == PH_TAIL) && tick && (bit_cnt == 5'd1);
  assign busy      = (phase != PH_IDLE);

  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE:  if (start)     phase_nxt = PH_SHIFT;
      PH_SHIFT: if (frame_end) phase_nxt = PH_TAIL;
      PH_TAIL:  if (gap_end)   phase_nxt = PH_IDLE;
      default:                 phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_IDLE;
    else        phase <= phase_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      is_rd    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_csb  <= 1'b1;
      spi_sclk <= 1'b0;
      spi_sdio <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (phase == PH_IDLE) begin
        hcnt <= '0;
        if (start) begin
          spi_csb  <= 1'b0;
          spi_sclk <= 1'b0;
          spi_sdio <= frame[FRAME_W-1];
          tx_sh    <= {frame[FRAME_W-2:0], 1'b0};
          is_rd    <= frame[RW_BIT];
          bit_cnt  <= '0;
          rx_sh    <= '0;
        end
      end else begin
        hcnt <= tick ? '0 : hcnt + 1'b1;
        if (tick) begin
          if (phase == PH_SHIFT) begin
            if (frame_end) begin
              spi_csb  <= 1'b1;
              spi_sdio <= 1'b0;
              bit_cnt  <= '0;
              if (is_rd) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
              end
            end else if (!spi_sclk) begin
              // Rising edge k = bit_cnt; data phase of a read is edges 8..15.
              spi_sclk <= 1'b1;
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt >= 5'd8) rx_sh <= {rx_sh[6:0], spi_sdo};
            end else begin
              // Falling edge k = bit_cnt-1; only edges 0..14 advance sdio.
              spi_sclk <= 1'b0;
              if (bit_cnt <= 5'd15) begin
                spi_sdio <= tx_sh[FRAME_W-1];
                tx_sh    <= {tx_sh[FRAME_W-2:0], 1'b0};
              end
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ad9783_spi_cfg.sv
// AD9783 configuration sequencer: writes the init table after reset or
// reinit, then serves single-register host reads/writes over valid/ready.
// Ports:
//   clk_in, rst_n_in             clock, asynchronous active-low reset
//   reinit_in                    pulse: rerun the init table
//   req_valid_in/req_ready_out   host request handshake
//   req_we_in, req_addr_in,
//   req_wdata_in                 request: 1=write, register address, data
//   rdata_out, rdata_valid_out   last read byte, 1-cycle update pulse
//   init_done_out                init table complete
//   spi_csb_out, spi_sclk_out,
//   spi_sdio_out, spi_sdo_in     DAC serial port
module ad9783_spi_cfg
  import ad9783_spi_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned N_INIT  = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       reinit_in,
  input  logic       req_valid_in,
  output logic       req_ready_out,
  input  logic       req_we_in,
  input  logic [4:0] req_addr_in,
  input  logic [7:0] req_wdata_in,
  output logic [7:0] rdata_out,
  output logic       rdata_valid_out,
  output logic       init_done_out,
  output logic       spi_csb_out,
  output logic       spi_sclk_out,
  output logic       spi_sdio_out,
  input  logic       spi_sdo_in
);

  localparam logic [3:0] LAST_IDX = 4'(N_INIT - 1);

  cfg_state_t         state, state_nxt;
  logic [3:0]         init_idx, idx_nxt;
  logic               init_done, done_nxt;
  logic               reinit_pend, pend_nxt;
  logic               in_init, in_init_nxt;
  logic               start;
  logic [FRAME_W-1:0] frame_word;
  logic [12:0]        entry;
  logic               accept;
  logic               phy_busy, frame_end, gap_end;

  assign req_ready_out = (state == ST_IDLE) && init_done && !reinit_pend && !phy_busy;
  assign accept        = req_valid_in && req_ready_out;
  assign init_done_out = init_done;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = init_idx;
    done_nxt    = init_done;
    pend_nxt    = reinit_pend | reinit_in;
    in_init_nxt = in_init;
    start       = 1'b0;
    entry       = init_entry(init_idx);
    frame_word  = make_frame(1'b0, entry[12:8], entry[7:0]);

    case (state)
      ST_RESET_IDLE: begin
        state_nxt   = ST_INIT_LOAD;
        idx_nxt     = '0;
        done_nxt    = 1'b0;
        in_init_nxt = 1'b1;
      end
      ST_INIT_LOAD: begin
        start     = 1'b1;
        state_nxt = ST_FRAME;
      end
      ST_FRAME: begin
        if (frame_end) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gap_end) begin
          if (in_init && (init_idx != LAST_IDX)) begin
            idx_nxt   = init_idx + 4'd1;
            state_nxt = ST_INIT_LOAD;
          end else if (pend_nxt) begin
            // A reinit latched during this frame is taken instead of entering IDLE.
            state_nxt   = ST_INIT_LOAD;
            idx_nxt     = '0;
            done_nxt    = 1'b0;
            in_init_nxt = 1'b1;
            pend_nxt    = 1'b0;
          end else begin
            state_nxt   = ST_IDLE;
            in_init_nxt = 1'b0;
            if (in_init) done_nxt = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          // A same-cycle reinit stays latched in pend_nxt and runs after this frame.
          start       = 1'b1;
          frame_word  = make_frame(~req_we_in, req_addr_in,
                                   req_we_in ? req_wdata_in : 8'h00);
          state_nxt   = ST_FRAME;
          in_init_nxt = 1'b0;
        end else if (pend_nxt) begin
          // Launch entry 0 straight from IDLE rather than via INIT_LOAD.
          entry       = init_entry(4'd0);
          frame_word  = make_frame(1'b0, entry[12:8], entry[7:0]);
          start       = 1'b1;
          state_nxt   = ST_FRAME;
          idx_nxt     = '0;
          done_nxt    = 1'b0;
          in_init_nxt = 1'b1;
          pend_nxt    = 1'b0;
        end
      end
      default: state_nxt = ST_RESET_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_RESET_IDLE;
      init_idx    <= '0;
      init_done   <= 1'b0;
      reinit_pend <= 1'b0;
      in_init     <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_idx    <= idx_nxt;
      init_done   <= done_nxt;
      reinit_pend <= pend_nxt;
      in_init     <= in_init_nxt;
    end
  end

  ad9783_spi_phy #(
    .CLK_DIV (CLK_DIV)
  ) u_phy (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .start     (start),
    .frame     (frame_word),
    .busy      (phy_busy),
    .frame_end (frame_end),
    .gap_end   (gap_end),
    .rx_data   (rdata_out),
    .rx_valid  (rdata_valid_out),
    .spi_csb   (spi_csb_out),
    .spi_sclk  (spi_sclk_out),
    .spi_sdio  (spi_sdio_out),
    .spi_sdo   (spi_sdo_in)
  );

endmodule

// File: tb/tb_ad9783_spi_cfg.sv
// Bench for ad9783_spi_cfg (CLK_DIV=4, N_INIT=4): an SPI slave model
// records each frame and returns a programmable read byte; expected frames,
// read data and timing are derived from the frame format and cycle counts.
module tb_ad9783_spi_cfg;

  localparam int unsigned CD = 4;
  localparam int unsigned NI = 4;
  localparam int unsigned T_CSB_UP = 33 * CD;   // 132
  localparam int unsigned T_READY  = 35 * CD;   // 140

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       reinit_in;
  logic       req_valid_in;
  logic       req_ready_out;
  logic       req_we_in;
  logic [4:0] req_addr_in;
  logic [7:0] req_wdata_in;
  logic [7:0] rdata_out;
  logic       rdata_valid_out;
  logic       init_done_out;
  logic       spi_csb_out;
  logic       spi_sclk_out;
  logic       spi_sdio_out;
  logic       spi_sdo_in = 1'b0;

  ad9783_spi_cfg #(
    .CLK_DIV (CD),
    .N_INIT  (NI)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .reinit_in       (reinit_in),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .req_we_in       (req_we_in),
    .req_addr_in     (req_addr_in),
    .req_wdata_in    (req_wdata_in),
    .rdata_out       (rdata_out),
    .rdata_valid_out (rdata_valid_out),
    .init_done_out   (init_done_out),
    .spi_csb_out     (spi_csb_out),
    .spi_sclk_out    (spi_sclk_out),
    .spi_sdio_out    (spi_sdio_out),
    .spi_sdo_in      (spi_sdo_in)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI slave / observers ----------------
  typedef struct {
    logic [15:0] word;
    int unsigned fall;
    int unsigned len;
    int unsigned rises;
  } frame_t;

  frame_t      fq[$];
  int unsigned rv_cyc[$];
  logic [7:0]  rv_dat[$];
  int unsigned done_rise[$];
  int unsigned done_fall[$];
  logic [7:0]  sdo_byte = 8'h00;

  logic        pcsb = 1'b1, psclk = 1'b0, pdone = 1'b0;
  logic [15:0] sh = '0;
  int unsigned nb = 0, fall_c = 0;
  logic [2:0]  bi;

  always @(negedge clk_in) begin
    if (pcsb && !spi_csb_out) begin
      fall_c = cyc; nb = 0; sh = '0; spi_sdo_in = 1'b0;
    end
    if (!spi_csb_out && !psclk && spi_sclk_out) begin
      sh = {sh[14:0], spi_sdio_out};
      nb++;
    end
    if (!spi_csb_out && psclk && !spi_sclk_out && nb >= 8 && nb < 16) begin
      bi = 3'(15 - nb);
      spi_sdo_in = sdo_byte[bi];
    end
    if (!pcsb && spi_csb_out) begin
      fq.push_back('{sh, fall_c, cyc - fall_c, nb});
      spi_sdo_in = 1'b0;
    end
    if (rdata_valid_out) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back(rdata_out);
    end
    if (init_done_out && !pdone) done_rise.push_back(cyc);
    if (!init_done_out && pdone) done_fall.push_back(cyc);
    pcsb = spi_csb_out; psclk = spi_sclk_out; pdone = init_done_out;
  end

  // ---------------- reference ----------------
  function automatic logic [15:0] exp_frame(input logic we, input logic [4:0] a, input logic [7:0] d);
    int unsigned w;
    w = (we ? 0 : 32768) + int'(a) * 256 + (we ? int'(d) : 0);
    return 16'(w);
  endfunction

  function automatic logic [15:0] exp_init(input int unsigned i);
    int unsigned addrs[4] = '{0, 2, 3, 4};
    return 16'(addrs[i] * 256);
  endfunction

  // ---------------- helpers ----------------
  task automatic clear_q();
    fq.delete(); rv_cyc.delete(); rv_dat.delete(); done_rise.delete(); done_fall.delete();
  endtask

  task automatic issue(input logic we, input logic [4:0] a, input logic [7:0] d,
                       input bit with_reinit, output int unsigned acc);
    bit ok = 0;
    acc = 0;
    req_we_in = we; req_addr_in = a; req_wdata_in = d; req_valid_in = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (req_ready_out) begin
        acc = cyc; ok = 1;
        if (with_reinit) reinit_in = 1'b1;
        @(negedge clk_in);
        req_valid_in = 1'b0; reinit_in = 1'b0;
        req_we_in = 1'($urandom); req_addr_in = 5'($urandom); req_wdata_in = 8'($urandom);
        break;
      end
      @(negedge clk_in);
    end
    check_eq("accept_in_time", 32'(ok), 32'd1);
  endtask

  task automatic wait_frames(input int unsigned n);
    for (int i = 0; i < 6000 && fq.size() < n; i++) @(negedge clk_in);
    repeat (10) @(negedge clk_in);
    check_eq("frame_count", fq.size(), n);
  endtask

  task automatic check_init_run(input int unsigned first);
    for (int unsigned i = 0; i < NI; i++) begin
      if (fq.size() > first + i) begin
        check_eq("init_word", fq[first+i].word, exp_init(i));
        check_eq("init_len", fq[first+i].len, T_CSB_UP);
        check_eq("init_rises", fq[first+i].rises, 16);
        if (i > 0)
          check_eq("init_gap_ge8",
                   32'(fq[first+i].fall >= fq[first+i-1].fall + fq[first+i-1].len + 8), 32'd1);
      end
    end
  endtask

  int unsigned acc;
  logic        we;
  logic [4:0]  a;
  logic [7:0]  d;
  logic [15:0] held_word;

  initial begin
    rst_n_in = 1'b0; reinit_in = 1'b0; req_valid_in = 1'b0;
    req_we_in = 1'b0; req_addr_in = '0; req_wdata_in = '0;
    repeat (3) @(negedge clk_in);

    // Reset values
    check_eq("rst_csb", spi_csb_out, 1'b1);
    check_eq("rst_sclk", spi_sclk_out, 1'b0);
    check_eq("rst_sdio", spi_sdio_out, 1'b0);
    check_eq("rst_ready", req_ready_out, 1'b0);
    check_eq("rst_init_done", init_done_out, 1'b0);
    check_eq("rst_rdata", rdata_out, 8'h00);
    check_eq("rst_rvalid", rdata_valid_out, 1'b0);

    // Request held from reset: must follow the last init frame, exactly once.
    a = 5'($urandom); d = 8'($urandom);
    held_word = exp_frame(1'b1, a, d);
    req_we_in = 1'b1; req_addr_in = a; req_wdata_in = d; req_valid_in = 1'b1;
    rst_n_in = 1'b1;
    issue(1'b1, a, d, 1'b0, acc);
    wait_frames(NI + 1);
    check_init_run(0);
    if (fq.size() == NI + 1 && done_rise.size() > 0) begin
      check_eq("init_done_time", done_rise[0], fq[NI-1].fall + T_READY);
      check_eq("held_accept_time", acc, fq[NI-1].fall + T_READY);
      check_eq("held_word", fq[NI].word, held_word);
      check_eq("held_fall", fq[NI].fall, acc + 1);
    end else check_eq("init_done_seen", done_rise.size(), 1);
    repeat (300) @(negedge clk_in);
    check_eq("held_once", fq.size(), NI + 1);
    check_eq("init_write_no_rvalid", rv_cyc.size(), 0);
    check_eq("ready_after_init", req_ready_out, 1'b1);
    clear_q();

    // Directed write and read, then randomized transactions.
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin we = 1'b1; a = 5'h0A; d = 8'h5C; sdo_byte = 8'h00; end
      else if (t == 1) begin we = 1'b0; a = 5'h1F; d = 8'h77; sdo_byte = 8'hA5; end
      else begin we = 1'($urandom); a = 5'($urandom); d = 8'($urandom); sdo_byte = 8'($urandom); end
      issue(we, a, d, 1'b0, acc);
      wait_frames(1);
      if (fq.size() == 1) begin
        check_eq("host_word", fq[0].word, exp_frame(we, a, d));
        check_eq("host_len", fq[0].len, T_CSB_UP);
        check_eq("host_fall", fq[0].fall, acc + 1);
        if (we) check_eq("write_no_rvalid", rv_cyc.size(), 0);
        else begin
          check_eq("read_rvalid_count", rv_cyc.size(), 1);
          if (rv_cyc.size() == 1) begin
            check_eq("read_rdata", rv_dat[0], sdo_byte);
            check_eq("read_rvalid_time", rv_cyc[0], fq[0].fall + T_CSB_UP);
          end
        end
      end
      clear_q();
    end

    // Reinit mid-read with a request waiting behind it.
    a = 5'($urandom); sdo_byte = 8'($urandom);
    issue(1'b0, a, 8'h00, 1'b0, acc);
    repeat (50) @(negedge clk_in);
    reinit_in = 1'b1;
    @(negedge clk_in);
    reinit_in = 1'b0;
    held_word = exp_frame(1'b1, 5'h0A, 8'h3C);
    issue(1'b1, 5'h0A, 8'h3C, 1'b0, acc);
    wait_frames(NI + 2);
    if (fq.size() == NI + 2) begin
      check_eq("ri_read_word", fq[0].word, exp_frame(1'b0, a, 8'h00));
      check_init_run(1);
      check_eq("ri_init_start", fq[1].fall, fq[0].fall + T_READY + 1);
      check_eq("ri_req_word", fq[NI+1].word, held_word);
      if (rv_dat.size() == 1) check_eq("ri_rdata", rv_dat[0], sdo_byte);
      else check_eq("ri_rvalid_count", rv_dat.size(), 1);
      if (done_fall.size() == 1 && done_rise.size() == 1) begin
        check_eq("ri_done_fall", done_fall[0], fq[0].fall + T_READY);
        check_eq("ri_done_rise", done_rise[0], fq[NI].fall + T_READY);
      end else check_eq("ri_done_edges", done_fall.size() + done_rise.size(), 2);
    end
    clear_q();

    // Reinit in the same cycle as acceptance: request first, then init table.
    a = 5'($urandom); d = 8'($urandom);
    issue(1'b1, a, d, 1'b1, acc);
    wait_frames(NI + 1);
    if (fq.size() == NI + 1) begin
      check_eq("same_req_word", fq[0].word, exp_frame(1'b1, a, d));
      check_init_run(1);
    end
    check_eq("same_done_back", init_done_out, 1'b1);
    clear_q();

    // Reset at t=40 of a frame.
    issue(1'b1, 5'($urandom), 8'($urandom), 1'b0, acc);
    repeat (40) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check_eq("abort_csb", spi_csb_out, 1'b1);
    check_eq("abort_sclk", spi_sclk_out, 1'b0);
    check_eq("abort_init_done", init_done_out, 1'b0);
    repeat (3) @(negedge clk_in);
    clear_q();
    rst_n_in = 1'b1;
    wait_frames(NI);
    check_init_run(0);
    for (int i = 0; i < 400 && done_rise.size() == 0; i++) @(negedge clk_in);
    if (done_rise.size() == 1 && fq.size() == NI)
      check_eq("abort_done_time", done_rise[0], fq[NI-1].fall + T_READY);
    else check_eq("abort_done_seen", done_rise.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
